// File: rtl/instruction_register_pkg.sv
// Shared constants for the JTAG-style instruction register: default width
// and the BYPASS pattern loaded into the update stage on reset.
package instruction_register_pkg;

    localparam int IR_SIZE_DEFAULT = 4;
    localparam int IR_SIZE_MIN     = 2;
    localparam int IR_SIZE_MAX     = 32;

    // BYPASS is all ones at every legal width; cells pick their own bit.
    localparam logic [IR_SIZE_MAX-1:0] BYPASS = '1;

    function automatic logic bypass_bit(input int idx);
        logic [IR_SIZE_MAX-1:0] code;
        code = BYPASS;
        return code[idx];
    endfunction

endpackage

// File: rtl/instruction_register_if.sv
// Control and data signals of the instruction register; the controller
// (TAP side) drives through master, the register implements slave.
interface instruction_register_if #(
    parameter int IR_SIZE = instruction_register_pkg::IR_SIZE_DEFAULT
);
    logic               ShiftIR;
    logic               UpdateIR;
    logic               scan_in;
    logic [IR_SIZE-1:0] data_in;
    logic               scan_out;
    logic [IR_SIZE-1:0] data_out;

    modport master (
        output ShiftIR,
        output UpdateIR,
        output scan_in,
        output data_in,
        input  scan_out,
        input  data_out
    );

    modport slave (
        input  ShiftIR,
        input  UpdateIR,
        input  scan_in,
        input  data_in,
        output scan_out,
        output data_out
    );
endinterface

// File: rtl/instruction_register_cell.sv
// One instruction-register bit: edge-triggered shift/capture flop feeding a
// transparent-high update latch.
module instruction_register_cell #(
    parameter logic UR_RESET = 1'b1
) (
    input  logic ClockIR,
    input  logic reset,
    input  logic shift_ir,
    input  logic update_ir,
    input  logic capture_bit,
    input  logic scan_bit,
    output logic sr_bit,
    output logic ur_bit
);

    always_ff @(posedge ClockIR or posedge reset) begin
        if (reset)
            sr_bit <= 1'b0;
        else if (shift_ir)
            sr_bit <= scan_bit;
        else
            sr_bit <= capture_bit;
    end

    // Reset dominates the enable so BYPASS holds even with UpdateIR high.
    always_latch begin
        if (reset)
            ur_bit <= UR_RESET;
        else if (update_ir)
            ur_bit <= sr_bit;
    end

endmodule

// File: rtl/instruction_register.sv
// Instruction register built from a chain of cells:
// scan_in -> cell[IR_SIZE-1] -> ... -> cell[0] -> scan_out.
module instruction_register
    import instruction_register_pkg::*;
#(
    parameter int IR_SIZE = IR_SIZE_DEFAULT
) (
    input logic                    ClockIR,
    input logic                    reset,
    instruction_register_if.slave  ir
);

    logic [IR_SIZE:0]   chain;
    logic [IR_SIZE-1:0] ur;

    assign chain[IR_SIZE] = ir.scan_in;

    for (genvar i = 0; i < IR_SIZE; i++) begin : g_cell
        instruction_register_cell #(
            .UR_RESET (bypass_bit(i))
        ) u_cell (
            .ClockIR     (ClockIR),
            .reset       (reset),
            .shift_ir    (ir.ShiftIR),
            .update_ir   (ir.UpdateIR),
            .capture_bit (ir.data_in[i]),
            .scan_bit    (chain[i+1]),
            .sr_bit      (chain[i]),
            .ur_bit      (ur[i])
        );
    end

    // scan_out is taken straight from SR[0], no retiming stage.
    assign ir.scan_out = chain[0];
    assign ir.data_out = ur;

endmodule

// File: tb/tb_instruction_register.sv
// Directed and randomized checks of instruction_register against a
// bit-vector reference model.
module tb_instruction_register;

    localparam int N    = 4;
    localparam int MASK = (1 << N) - 1;

    logic ClockIR;
    logic reset;
    int   tests;
    int   fails;
    int   m_sr;
    int   m_ur;

    instruction_register_if #(.IR_SIZE(N)) ifc ();

    instruction_register #(.IR_SIZE(N)) dut (
        .ClockIR (ClockIR),
        .reset   (reset),
        .ir      (ifc.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".scan_out"}, {31'd0, ifc.scan_out}, m_sr & 1);
        chk({tag, ".data_out"}, {28'd0, ifc.data_out}, m_ur);
    endtask

    // One ClockIR pulse; the model applies the edge rule, then the latch.
    task automatic pulse;
        ClockIR = 1'b1;
        if (ifc.ShiftIR)
            m_sr = (m_sr >> 1) | (int'(ifc.scan_in) << (N - 1));
        else
            m_sr = int'(ifc.data_in);
        if (ifc.UpdateIR) m_ur = m_sr;
        #5;
        ClockIR = 1'b0;
        #5;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        ClockIR = 1'b0;
        ifc.ShiftIR  = 1'($urandom);
        ifc.UpdateIR = 1'($urandom);
        ifc.scan_in  = 1'($urandom);
        ifc.data_in  = 4'($urandom);
        reset = 1'b1;
        m_sr = 0;
        m_ur = MASK;
        #2;
        check_outputs("reset_async");
        ClockIR = 1'b1; #5; ClockIR = 1'b0; #5;
        check_outputs("reset_clocked");

        ifc.UpdateIR = 1'b0;
        #3;
        reset = 1'b0;
        #5;
        check_outputs("reset_release_hold");

        ifc.ShiftIR = 1'b1;
        ifc.scan_in = 1'b1;
        for (int i = 0; i < N; i++) begin
            pulse();
            check_outputs($sformatf("scan_in_edge%0d", i));
        end
        chk("scan_in_sr_full", m_sr, MASK);

        ifc.UpdateIR = 1'b1;
        #2;
        m_ur = m_sr;
        chk("update_transparent", {28'd0, ifc.data_out}, 32'hF);
        ifc.UpdateIR = 1'b0;
        #2;

        ifc.ShiftIR = 1'b0;
        ifc.data_in = 4'hA;
        pulse();
        check_outputs("capture_A");
        chk("capture_holds_F", {28'd0, ifc.data_out}, 32'hF);

        ifc.ShiftIR = 1'b1;
        ifc.scan_in = 1'b1;
        chk("scan_out_before", {31'd0, ifc.scan_out}, 32'd0);
        for (int i = 0; i < N; i++) begin
            pulse();
            check_outputs($sformatf("scan_out_edge%0d", i));
        end
        chk("scan_out_sr_end", m_sr, MASK);

        ifc.UpdateIR = 1'b1;
        #1;
        m_ur = m_sr;
        for (int i = 0; i < 6; i++) begin
            ifc.ShiftIR = 1'($urandom);
            ifc.scan_in = 1'($urandom);
            ifc.data_in = 4'($urandom);
            #1;
            pulse();
            check_outputs($sformatf("follow_edge%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            ifc.ShiftIR  = 1'($urandom);
            ifc.scan_in  = 1'($urandom);
            ifc.data_in  = 4'($urandom);
            ifc.UpdateIR = 1'($urandom);
            #1;
            if (ifc.UpdateIR) m_ur = m_sr;
            check_outputs($sformatf("rand_pre%0d", i));
            pulse();
            check_outputs($sformatf("rand_post%0d", i));
        end

        ifc.UpdateIR = 1'b1;
        ifc.ShiftIR  = 1'b1;
        ifc.scan_in  = 1'b1;
        #1;
        m_ur = m_sr;
        pulse();
        pulse();
        #2;
        reset = 1'b1;
        m_sr = 0;
        m_ur = MASK;
        #1;
        check_outputs("reset_mid_update");
        #3;
        reset = 1'b0;
        #1;
        m_ur = m_sr;
        check_outputs("reset_release_follow");

        ifc.UpdateIR = 1'b0;
        #1;
        pulse();
        pulse();
        check_outputs("preshift_no_update");
        reset = 1'b1;
        m_sr = 0;
        m_ur = MASK;
        #2;
        reset = 1'b0;
        #2;
        check_outputs("reset_mid_shift");
        ifc.scan_in = 1'b0;
        pulse();
        check_outputs("first_edge_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
